// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port cache-line memory arbiter.
// The MEM_ARB_RR_EN macro is not used here; see mem_arb_pick.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 256;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between dcache (m0) and icache (m1).
// MEM_ARB_RR_EN: tie goes to the pointer; otherwise m0 always wins a tie.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic ptr_i,
    output logic win_o
);

    logic tie_win;

`ifdef MEM_ARB_RR_EN
    assign tie_win = ptr_i;
`else
    logic ptr_unused;
    assign ptr_unused = ptr_i;
    assign tie_win    = OWNER_M0;
`endif

    // Sole requester wins; a tie is settled by tie_win.
    always_comb begin
        win_o = OWNER_M0;
        unique case (1'b1)
            (req0_i && req1_i):  win_o = tie_win;
            (req0_i && !req1_i): win_o = OWNER_M0;
            (!req0_i && req1_i): win_o = OWNER_M1;
            default:             win_o = OWNER_M0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates dcache and icache line requests onto one Data_Memory port.
// Define MEM_ARB_RR_EN for round-robin; default is fixed m0 priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              owner_o
);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                ptr_q, ptr_d;
    logic                en_q, en_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                win;

    mem_arb_pick u_pick (
        .req0_i (m0_enable_i),
        .req1_i (m1_enable_i),
        .ptr_i  (ptr_q),
        .win_o  (win)
    );

    // Next state, latched request and completion pulses.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        en_d    = en_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m0_enable_i || m1_enable_i) begin
                    state_d = BUSY;
                    owner_d = win;
                    en_d    = 1'b1;
                    if (win == OWNER_M1) begin
                        we_d   = m1_write_i;
                        addr_d = m1_addr_i;
                        data_d = m1_data_i;
                    end else begin
                        we_d   = m0_write_i;
                        addr_d = m0_addr_i;
                        data_d = m0_data_i;
                    end
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    state_d = DONE;
                    en_d    = 1'b0;
                    ptr_d   = ~owner_q;
                    ack0_d  = (owner_q == OWNER_M0);
                    ack1_d  = (owner_q == OWNER_M1);
                    if (!we_q) begin
                        rdata_d = mem_data_i;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= OWNER_M0;
            ptr_q   <= OWNER_M0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    assign m0_ack_o     = ack0_q;
    assign m1_ack_o     = ack1_q;
    assign rdata_o      = rdata_q;
    assign mem_enable_o = en_q;
    assign mem_write_o  = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_data_o   = data_q;
    assign owner_o      = owner_q;

endmodule
